// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage CPU.
//
// Generates the per-cycle pipeline steering signals:
//   * load-use bubble: PC and IF/ID are frozen for one cycle and the ID-stage
//     control mux is told to zero the WB/MEM/EX fields entering ID/EX
//   * taken-branch flush of IF/ID
//   * full pipeline freeze while a multi-cycle data-memory access is pending
// It also keeps saturating statistics on load-use bubbles and memory-wait
// cycles, and raises a sticky error when a memory access waits too long.
//
// Parameters
//   REG_AW   register address width
//   CNT_W    width of the stall statistics counters
//   TIMEOUT  MEM_WAIT cycles before err_o sets (>= 2)
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-low reset
//   ifid_rs_i       rs field of the instruction in ID
//   ifid_rt_i       rt field of the instruction in ID
//   ifid_uses_rt_i  ID instruction reads rt as a source
//   idex_memread_i  instruction in EX is a load
//   idex_rt_i       destination rt of the instruction in EX
//   branch_taken_i  branch resolved taken in ID this cycle
//   dmem_req_i      MEM stage has a data-memory access this cycle
//   dmem_ack_i      data memory completes the access this cycle
//   pc_write_o      PC update enable
//   ifid_write_o    IF/ID register write enable
//   bubble_o        control mux select, 1 = zero WB/MEM/EX controls
//   ifid_flush_o    clear IF/ID to NOP
//   pipe_hold_o     hold ID/EX, EX/MEM, MEM/WB registers
//   lu_cnt_o        load-use bubbles inserted (saturating)
//   mw_cnt_o        memory-wait cycles (saturating)
//   err_o           sticky memory-acknowledge timeout flag
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] ifid_rs_i,
   input  logic [REG_AW-1:0] ifid_rt_i,
   input  logic              ifid_uses_rt_i,
   input  logic              idex_memread_i,
   input  logic [REG_AW-1:0] idex_rt_i,
   input  logic              branch_taken_i,
   input  logic              dmem_req_i,
   input  logic              dmem_ack_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              bubble_o,
   output logic              ifid_flush_o,
   output logic              pipe_hold_o,
   output logic [CNT_W-1:0]  lu_cnt_o,
   output logic [CNT_W-1:0]  mw_cnt_o,
   output logic              err_o
);

   // wcnt only needs to reach TIMEOUT-1; it parks there once reached
   localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [CNT_W-1:0]    lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0]    mw_cnt_q, mw_cnt_d;
   logic                err_q, err_d;

   logic                lu;
   logic                ms;
   logic                lu_evt;

   // ------------------------------------------------------------------
   // Hazard terms
   // ------------------------------------------------------------------
   always_comb begin
      lu = 1'b0;
      if (idex_memread_i && (idex_rt_i != '0)) begin
         if (idex_rt_i == ifid_rs_i) begin
            lu = 1'b1;
         end else if (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)) begin
            lu = 1'b1;
         end
      end
      // an ack without a request is simply not a stall
      ms = dmem_req_i & ~dmem_ack_i;
   end

   // ------------------------------------------------------------------
   // Next state and control outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      bubble_o     = 1'b0;
      ifid_flush_o = 1'b0;
      pipe_hold_o  = 1'b0;
      lu_evt       = 1'b0;

      if (!rst_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         bubble_o     = 1'b1;
         state_d      = RUN;
      end else begin
         // memory stall outranks everything; the ack cycle still holds
         if ((state_q == MEM_WAIT) || ms) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
         end else if (lu) begin
            // branch flush deliberately dropped: the branch re-resolves
            // next cycle with forwarded load data
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            bubble_o     = 1'b1;
            lu_evt       = 1'b1;
         end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
         end

         unique case (state_q)
            RUN: begin
               if (ms) begin
                  state_d = MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (dmem_ack_i) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Wait counter, timeout flag and statistics
   // ------------------------------------------------------------------
   always_comb begin
      wcnt_d   = '0;
      err_d    = err_q;
      lu_cnt_d = lu_cnt_q;
      mw_cnt_d = mw_cnt_q;

      if (state_q == MEM_WAIT) begin
         if (wcnt_q == WCNT_LAST) begin
            err_d  = 1'b1;
            wcnt_d = wcnt_q;
         end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
         end
      end

      if (lu_evt && (lu_cnt_q != '1)) begin
         lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end

      if (pipe_hold_o && (mw_cnt_q != '1)) begin
         mw_cnt_d = mw_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= RUN;
         wcnt_q   <= '0;
         lu_cnt_q <= '0;
         mw_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         lu_cnt_q <= lu_cnt_d;
         mw_cnt_q <= mw_cnt_d;
         err_q    <= err_d;
      end
   end

   assign lu_cnt_o = lu_cnt_q;
   assign mw_cnt_o = mw_cnt_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Drives two hazard_ctrl instances with identical inputs: one with default
// parameters and one with CNT_W=2 / TIMEOUT=4 so saturation and timeout are
// reachable quickly. Each cycle every output of both instances is compared
// against a behavioural reference model of the hazard rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int unsigned AW = 5;

   logic          clk;
   logic          rst_i;
   logic [AW-1:0] ifid_rs_i, ifid_rt_i, idex_rt_i;
   logic          ifid_uses_rt_i, idex_memread_i, branch_taken_i;
   logic          dmem_req_i, dmem_ack_i;

   logic          a_pc, a_ifw, a_bub, a_fl, a_hold, a_err;
   logic [15:0]   a_lu, a_mw;
   logic          b_pc, b_ifw, b_bub, b_fl, b_hold, b_err;
   logic [1:0]    b_lu, b_mw;

   int            checks = 0;
   int            errors = 0;

   // reference model state, index 0 = default instance, 1 = small instance
   int            P_TO  [2] = '{64, 4};
   int            P_MAX [2] = '{65535, 3};
   bit            m_wait[2];
   int            m_wc  [2];
   int            m_lu  [2];
   int            m_mw  [2];
   bit            m_err [2];

   hazard_ctrl u_a (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .ifid_uses_rt_i (ifid_uses_rt_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .branch_taken_i (branch_taken_i),
      .dmem_req_i     (dmem_req_i),
      .dmem_ack_i     (dmem_ack_i),
      .pc_write_o     (a_pc),
      .ifid_write_o   (a_ifw),
      .bubble_o       (a_bub),
      .ifid_flush_o   (a_fl),
      .pipe_hold_o    (a_hold),
      .lu_cnt_o       (a_lu),
      .mw_cnt_o       (a_mw),
      .err_o          (a_err)
   );

   hazard_ctrl #(
      .REG_AW  (AW),
      .CNT_W   (2),
      .TIMEOUT (4)
   ) u_b (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .ifid_uses_rt_i (ifid_uses_rt_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .branch_taken_i (branch_taken_i),
      .dmem_req_i     (dmem_req_i),
      .dmem_ack_i     (dmem_ack_i),
      .pc_write_o     (b_pc),
      .ifid_write_o   (b_ifw),
      .bubble_o       (b_bub),
      .ifid_flush_o   (b_fl),
      .pipe_hold_o    (b_hold),
      .lu_cnt_o       (b_lu),
      .mw_cnt_o       (b_mw),
      .err_o          (b_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_inc(input int v, input int mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   // One clock cycle: drive inputs after the falling edge, compare both
   // instances against the model, then advance the model over the next
   // rising edge.
   task automatic do_cycle(input bit r, input int rs, input int rt, input bit ur,
                           input bit mr, input int xrt, input bit br,
                           input bit rq, input bit ak);
      bit luhit;
      @(negedge clk);
      rst_i          = r;
      ifid_rs_i      = AW'(rs);
      ifid_rt_i      = AW'(rt);
      ifid_uses_rt_i = ur;
      idex_memread_i = mr;
      idex_rt_i      = AW'(xrt);
      branch_taken_i = br;
      dmem_req_i     = rq;
      dmem_ack_i     = ak;
      #1;
      luhit = mr && (xrt != 0) && ((xrt == rs) || (ur && (xrt == rt)));
      for (int k = 0; k < 2; k++) begin
         bit e_pc, e_ifw, e_bub, e_fl, e_hold;
         logic [31:0] o_lu, o_mw;
         logic [4:0]  o_ctl;
         if (!r) begin
            {e_pc, e_ifw, e_bub, e_fl, e_hold} = 5'b00100;
         end else if (m_wait[k] || (rq && !ak)) begin
            {e_pc, e_ifw, e_bub, e_fl, e_hold} = 5'b00001;
         end else if (luhit) begin
            {e_pc, e_ifw, e_bub, e_fl, e_hold} = 5'b00100;
         end else if (br) begin
            {e_pc, e_ifw, e_bub, e_fl, e_hold} = 5'b11010;
         end else begin
            {e_pc, e_ifw, e_bub, e_fl, e_hold} = 5'b11000;
         end
         if (k == 0) begin
            o_ctl = {a_pc, a_ifw, a_bub, a_fl, a_hold};
            o_lu  = 32'(a_lu);
            o_mw  = 32'(a_mw);
         end else begin
            o_ctl = {b_pc, b_ifw, b_bub, b_fl, b_hold};
            o_lu  = 32'(b_lu);
            o_mw  = 32'(b_mw);
         end
         check($sformatf("pc_write[%0d]", k),   32'(o_ctl[4]), 32'(e_pc));
         check($sformatf("ifid_write[%0d]", k), 32'(o_ctl[3]), 32'(e_ifw));
         check($sformatf("bubble[%0d]", k),     32'(o_ctl[2]), 32'(e_bub));
         check($sformatf("ifid_flush[%0d]", k), 32'(o_ctl[1]), 32'(e_fl));
         check($sformatf("pipe_hold[%0d]", k),  32'(o_ctl[0]), 32'(e_hold));
         check($sformatf("lu_cnt[%0d]", k),     o_lu, 32'(m_lu[k]));
         check($sformatf("mw_cnt[%0d]", k),     o_mw, 32'(m_mw[k]));
         check($sformatf("err[%0d]", k),        32'((k == 0) ? a_err : b_err), 32'(m_err[k]));

         // model advance for the coming rising edge
         if (!r) begin
            m_wait[k] = 1'b0;
            m_wc[k]   = 0;
            m_lu[k]   = 0;
            m_mw[k]   = 0;
            m_err[k]  = 1'b0;
         end else begin
            if (e_hold) m_mw[k] = sat_inc(m_mw[k], P_MAX[k]);
            if (e_bub)  m_lu[k] = sat_inc(m_lu[k], P_MAX[k]);
            if (m_wait[k]) begin
               m_wc[k]++;
               if (m_wc[k] >= P_TO[k]) m_err[k] = 1'b1;
               if (ak) begin
                  m_wait[k] = 1'b0;
                  m_wc[k]   = 0;
               end
            end else if (rq && !ak) begin
               m_wait[k] = 1'b1;
            end
         end
      end
   endtask

   initial begin
      rst_i          = 1'b0;
      ifid_rs_i      = '0;
      ifid_rt_i      = '0;
      ifid_uses_rt_i = 1'b0;
      idex_memread_i = 1'b0;
      idex_rt_i      = '0;
      branch_taken_i = 1'b0;
      dmem_req_i     = 1'b0;
      dmem_ack_i     = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_wait[k] = 1'b0; m_wc[k] = 0; m_lu[k] = 0; m_mw[k] = 0; m_err[k] = 1'b0;
      end

      // reset held two cycles with a load-use pattern on the inputs
      do_cycle(0, 8, 0, 0, 1, 8, 0, 0, 0);
      do_cycle(0, 8, 0, 0, 1, 8, 0, 0, 0);
      check("reset_pc_write", 32'(a_pc), 32'd0);
      check("reset_bubble",   32'(a_bub), 32'd1);

      // first normal cycle after reset: counters and err cleared
      do_cycle(1, 1, 2, 0, 0, 0, 0, 0, 0);
      check("reset_lu_cnt", 32'(a_lu), 32'd0);
      check("reset_mw_cnt", 32'(a_mw), 32'd0);
      check("reset_err",    32'(a_err), 32'd0);

      // load-use on rs with a taken branch: bubble wins, no flush
      do_cycle(1, 8, 3, 0, 1, 8, 1, 0, 0);
      check("lu_rs_bubble", 32'(a_bub), 32'd1);
      check("lu_rs_flush",  32'(a_fl),  32'd0);
      do_cycle(1, 8, 3, 0, 0, 8, 1, 0, 0);
      check("lu_cnt_after_lu", 32'(a_lu), 32'd1);
      check("branch_flush",    32'(a_fl), 32'd1);

      // no-hazard variants
      do_cycle(1, 0, 5, 1, 1, 0, 0, 0, 0);
      check("nohaz_r0_bubble", 32'(a_bub), 32'd0);
      do_cycle(1, 4, 9, 0, 1, 9, 0, 0, 0);
      check("nohaz_rt_unused_bubble", 32'(a_bub), 32'd0);
      do_cycle(1, 4, 9, 1, 1, 9, 0, 0, 0);
      check("lu_rt_bubble", 32'(a_bub), 32'd1);

      // memory wait: request, ack three cycles later
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
      check("ack_cycle_hold", 32'(a_hold), 32'd1);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("released_hold", 32'(a_hold), 32'd0);
      check("mw_cnt_4",      32'(a_mw),   32'd4);
      // same-cycle ack: no stall
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
      check("same_cycle_ack_hold", 32'(a_hold), 32'd0);
      // stray ack without request
      do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
      check("stray_ack_mw_cnt", 32'(a_mw), 32'd4);

      // timeout on the small instance: six cycles with no ack
      for (int i = 0; i < 6; i++) do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
      check("timeout_err_small", 32'(b_err), 32'd1);
      check("timeout_err_big",   32'(a_err), 32'd0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("err_sticky_after_ack", 32'(b_err), 32'd1);

      // reset in the middle of a wait
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("midwait_reset_hold", 32'(b_hold), 32'd0);
      check("midwait_reset_err",  32'(b_err),  32'd0);

      // five load-use events: small counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         do_cycle(1, 7, 0, 0, 1, 7, 0, 0, 0);
         do_cycle(1, 1, 2, 0, 0, 0, 0, 0, 0);
      end
      check("lu_sat_small", 32'(b_lu), 32'd3);
      check("lu_count_big", 32'(a_lu), 32'd5);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         do_cycle(($urandom_range(0, 49) != 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU; it generates the bubble select consumed by the ID-stage control mux. That mux zeroes the WB/MEM/EX control fields entering ID/EX. The block also drives PC/IF-ID write enables, the IF/ID flush on taken branch, and pipeline freeze during multi-cycle data-memory accesses. It tracks stall statistics and flags a memory-acknowledge timeout.

## Interface
- REG_AW, 5, register address width
- CNT_W, 16, width of stall counters
- TIMEOUT, 64, MEM_WAIT cycles before err_o sets (≥2)

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; one clock; synchronous, active-low
- ifid_rs_i  input  REG_AW  rs field of instruction in ID
- ifid_rt_i  input  REG_AW  rt field of instruction in ID
- ifid_uses_rt_i  input  1  ID instruction reads rt as a source
- idex_memread_i  input  1  instruction in EX is a load
- idex_rt_i  input  REG_AW  destination rt of instruction in EX
- branch_taken_i  input  1  branch resolved taken in ID this cycle
- dmem_req_i  input  1  MEM stage has a data-memory access this cycle
- dmem_ack_i  input  1  data memory completes the access this cycle
- pc_write_o  output  1  PC update enable
- ifid_write_o  output  1  IF/ID register write enable
- bubble_o  output  1  select to control mux; 1 = zero WB/MEM/EX controls
- ifid_flush_o  output  1  clear IF/ID to NOP
- pipe_hold_o  output  1  hold ID/EX, EX/MEM, MEM/WB registers
- lu_cnt_o  output  CNT_W  load-use bubbles inserted, saturating
- mw_cnt_o  output  CNT_W  memory-wait cycles, saturating
- err_o  output  1  sticky memory-timeout flag

## Operation
- FSM states: RUN, MEM_WAIT. State register updates synchronously. Control outputs are combinational from the state and current inputs.
- Hazard term `lu`:
  - Requires idex_memread_i=1 and idex_rt_i≠0.
  - Requires idex_rt_i==ifid_rs_i, or ifid_uses_rt_i=1 with idex_rt_i==ifid_rt_i.
- Memory stall term `ms` = dmem_req_i & ~dmem_ack_i.
- Priority, evaluated every cycle while rst_i=1: memory stall, then load-use, then branch flush, then normal.
  - MEM_WAIT, or RUN with ms=1: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, bubble_o=0, ifid_flush_o=0.
  - Else if lu=1: pc_write_o=0, ifid_write_o=0, bubble_o=1, pipe_hold_o=0, ifid_flush_o=0. Branch flush is suppressed, because the branch is re-evaluated next cycle with forwarded data.
  - Else if branch_taken_i=1: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1, bubble_o=0.
  - Else: pc_write_o=1, ifid_write_o=1, all others 0.
- Transitions:
  - RUN→MEM_WAIT when ms=1.
  - MEM_WAIT→RUN in the cycle dmem_ack_i=1.
  - In the ack cycle, outputs still follow the MEM_WAIT row. The pipeline releases on the following cycle.
- Wait counter wcnt (internal):
  - Cleared in RUN; increments each MEM_WAIT cycle.
  - When wcnt reaches TIMEOUT-1 while still in MEM_WAIT, err_o sets at the next edge.
  - err_o stays set until reset; the FSM keeps waiting.
- lu_cnt_o increments on every edge where lu drove bubble_o=1.
- mw_cnt_o increments on every edge where pipe_hold_o=1.
- Both counters saturate at all-ones with no wrap.
- dmem_ack_i with dmem_req_i=0 in RUN is ignored.

## Timing
- While rst_i=0, outputs are forced: pc_write_o=0, ifid_write_o=0, bubble_o=1, ifid_flush_o=0, pipe_hold_o=0.
- At the edge with rst_i=0:
  - state←RUN, wcnt←0, lu_cnt_o←0, mw_cnt_o←0, err_o←0.
  - Reset in MEM_WAIT abandons the wait; the first cycle after reset evaluates as RUN.
- Load-use costs exactly 1 bubble. The next cycle the load is in MEM, so lu deasserts without holding state.
- Memory access with ack arriving N cycles after the request: hold is asserted for N+1 cycles (request cycle through ack cycle). mw_cnt_o increases by N+1.
- Ack in the same cycle as the request: ms=0, no stall, state stays RUN.
- Counter outputs are registered and reflect events up to the previous edge.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with lu inputs active.
  - Outputs are pc_write_o=0, bubble_o=1; counters and err_o read 0 after reset.
- Load-use on rs: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8, branch_taken_i=1, one cycle.
  - bubble_o=1, pc_write_o=0, ifid_flush_o=0; lu_cnt_o=1 next cycle.
- No-hazard variants, each giving bubble_o=0:
  - idex_rt_i=0 with ifid_rs_i=0.
  - ifid_rt_i match with ifid_uses_rt_i=0.
- Memory wait: dmem_req_i=1, ack after 3 cycles.
  - pipe_hold_o=1 for 4 cycles, state back to RUN, mw_cnt_o=4.
  - Same-cycle ack gives 0 hold cycles.
- Timeout: TIMEOUT=4, no ack for 6 cycles.
  - err_o=1 after the 4th MEM_WAIT edge and stays set after ack.
  - Reset mid-wait clears err_o and releases hold.
- Saturation: CNT_W=2, 5 load-use events → lu_cnt_o=3.
